// File: rtl/binned_stream_histogram.sv
// Purpose : per-beat multi-word histogram; each kept word bumps the bin chosen by its upper bits.
// Latency : a beat lands in the counters 2 cycles after acceptance; a query returns 3 cycles after it is accepted.
// Backpressure: stream_ready = !busy. Beats and queries are refused or dropped while a clear/reset sweep runs.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   stream_valid/ready/keep/data beat input (WORDS words of word_width bits, keep bit per word)
//   clear_req, busy              start a clear sweep / sweep in progress
//   query_valid, query_bin       bin read request
//   query_out_valid, query_count read result (count forced to 0 when not valid)
//   overflow                     sticky: some increment reached the counter maximum
module binned_stream_histogram #(
    parameter int log2_words  = 3,
    parameter int word_width  = 12,
    parameter int log2_bins   = 8,
    parameter int count_width = 48,
    parameter int SATURATE    = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              stream_valid,
    output logic                              stream_ready,
    input  logic [2**log2_words-1:0]          stream_keep,
    input  logic [word_width*2**log2_words-1:0] stream_data,
    input  logic                              clear_req,
    output logic                              busy,
    input  logic                              query_valid,
    input  logic [log2_bins-1:0]              query_bin,
    output logic                              query_out_valid,
    output logic [count_width-1:0]            query_count,
    output logic                              overflow
);
    localparam int WORDS = 2**log2_words;
    localparam int BINS  = 2**log2_bins;
    localparam int IW    = log2_words + 1;               // holds 0..WORDS
    localparam int SW    = count_width + log2_words + 1; // count + increment without loss
    localparam logic [count_width-1:0] MAXC = '1;
    localparam logic [log2_bins:0]     LAST = {1'b0, {log2_bins{1'b1}}};

    typedef enum logic {SWEEP, RUN} state_t;

    state_t             state_q, state_d;
    // One bit wider than a bin index so reset can start at -1: the extra
    // sweep step gives the bins+1 busy cycles after reset, while a clear
    // starts at 0 and is busy for exactly bins cycles.
    logic [log2_bins:0] ptr_q, ptr_d;

    logic [count_width-1:0] counts [BINS];

    logic                                s1_vld;
    logic [WORDS-1:0]                    s1_keep;
    logic [WORDS-1:0][log2_bins-1:0]     s1_bin;

    logic [IW-1:0]          inc   [BINS];
    logic [SW-1:0]          sum_v [BINS];
    logic [count_width-1:0] nxt   [BINS];
    logic [BINS-1:0]        hit_max;

    logic                   q1_vld, q2_vld, q3_vld;
    logic [log2_bins-1:0]   q1_bin;
    logic [count_width-1:0] q2_cnt, q3_cnt;
    logic                   ovf_q;

    logic accept, clear_go;

    assign busy         = rst | (state_q == SWEEP);
    assign stream_ready = ~busy;
    assign accept       = stream_valid & stream_ready;
    assign clear_go     = clear_req & (state_q == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SWEEP;
            ptr_q   <= '1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            SWEEP: begin
                if (ptr_q == LAST) state_d = RUN;
                else               ptr_d   = ptr_q + (log2_bins+1)'(1);
            end
            RUN: begin
                if (clear_req) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end
            end
            default: state_d = SWEEP;
        endcase
    end

    // Every bin counts its matching kept words, so duplicates in a beat add up.
    always_comb begin
        hit_max = '0;
        for (int b = 0; b < BINS; b++) begin
            inc[b] = '0;
            for (int k = 0; k < WORDS; k++) begin
                if (s1_keep[k] && (s1_bin[k] == log2_bins'(b)))
                    inc[b] = inc[b] + IW'(1);
            end
            sum_v[b]   = SW'(counts[b]) + SW'(inc[b]);
            hit_max[b] = (inc[b] != '0) && (sum_v[b] >= SW'(MAXC));
            if ((SATURATE != 0) && hit_max[b]) nxt[b] = MAXC;
            else                                nxt[b] = sum_v[b][count_width-1:0];
        end
    end

    // Counter array has no reset of its own: the sweep that follows every
    // reset or clear zeroes it before any beat can be accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == SWEEP) begin
                counts[ptr_q[log2_bins-1:0]] <= '0;
            end else if (s1_vld && !clear_req) begin
                for (int b = 0; b < BINS; b++) counts[b] <= nxt[b];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_keep <= '0;
            s1_bin  <= '0;
            q1_vld  <= 1'b0;
            q1_bin  <= '0;
            q2_vld  <= 1'b0;
            q2_cnt  <= '0;
            q3_vld  <= 1'b0;
            q3_cnt  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            // A beat offered in the same cycle as a clear is thrown away.
            s1_vld  <= accept & ~clear_req;
            s1_keep <= stream_keep;
            for (int k = 0; k < WORDS; k++)
                s1_bin[k] <= stream_data[k*word_width + word_width - 1 -: log2_bins];

            if (clear_go)
                ovf_q <= 1'b0;
            else if (state_q == RUN && s1_vld && (|hit_max))
                ovf_q <= 1'b1;

            q1_vld <= query_valid & ~busy;
            q1_bin <= query_bin;
            q2_vld <= q1_vld;
            q2_cnt <= q1_vld ? counts[q1_bin] : '0;
            q3_vld <= q2_vld;
            q3_cnt <= q2_cnt;
        end
    end

    assign query_out_valid = q3_vld & ~rst;
    assign query_count     = query_out_valid ? q3_cnt : '0;
    assign overflow        = ovf_q & ~rst;

endmodule

// File: tb/tb_binned_stream_histogram.sv
module tb_binned_stream_histogram;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        stream_valid = 1'b0;
    logic [7:0]  stream_keep = '0;
    logic [95:0] stream_data = '0;
    logic        clear_req = 1'b0;
    logic        query_valid = 1'b0;
    logic [7:0]  query_bin = '0;

    logic        ready_a, busy_a, qov_a, ovf_a;
    logic [47:0] qcnt_a;
    logic        ready_s, busy_s, qov_s, ovf_s;
    logic [3:0]  qcnt_s;
    logic        ready_w, busy_w, qov_w, ovf_w;
    logic [3:0]  qcnt_w;

    int tests = 0;
    int fails = 0;

    localparam logic [47:0] MAX48 = '1;
    logic [47:0] model [256];

    binned_stream_histogram dut_a (
        .clk(clk), .rst(rst), .stream_valid(stream_valid), .stream_ready(ready_a),
        .stream_keep(stream_keep), .stream_data(stream_data), .clear_req(clear_req),
        .busy(busy_a), .query_valid(query_valid), .query_bin(query_bin),
        .query_out_valid(qov_a), .query_count(qcnt_a), .overflow(ovf_a));

    binned_stream_histogram #(.count_width(4), .SATURATE(1)) dut_s (
        .clk(clk), .rst(rst), .stream_valid(stream_valid), .stream_ready(ready_s),
        .stream_keep(stream_keep), .stream_data(stream_data), .clear_req(clear_req),
        .busy(busy_s), .query_valid(query_valid), .query_bin(query_bin),
        .query_out_valid(qov_s), .query_count(qcnt_s), .overflow(ovf_s));

    binned_stream_histogram #(.count_width(4), .SATURATE(0)) dut_w (
        .clk(clk), .rst(rst), .stream_valid(stream_valid), .stream_ready(ready_w),
        .stream_keep(stream_keep), .stream_data(stream_data), .clear_req(clear_req),
        .busy(busy_w), .query_valid(query_valid), .query_bin(query_bin),
        .query_out_valid(qov_w), .query_count(qcnt_w), .overflow(ovf_w));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void model_clear;
        for (int b = 0; b < 256; b++) model[b] = '0;
    endfunction

    // Reference: walk the kept words one at a time, bump the bin named by
    // the top 8 bits of each, clamp at the 48-bit maximum.
    function automatic void model_add(input logic [95:0] d, input logic [7:0] k);
        logic [11:0] w;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) begin
                w = d[i*12 +: 12];
                if (model[w[11:4]] != MAX48) model[w[11:4]] = model[w[11:4]] + 48'd1;
            end
        end
    endfunction

    task automatic send_beat(input logic [95:0] d, input logic [7:0] k, output bit acc);
        stream_valid = 1'b1;
        stream_data  = d;
        stream_keep  = k;
        acc = ready_a;
        if (acc) model_add(d, k);
        tick;
        stream_valid = 1'b0;
    endtask

    task automatic do_query(input logic [7:0] b, output logic va, output logic [47:0] ca,
                            output logic [3:0] cs, output logic [3:0] cw);
        query_valid = 1'b1;
        query_bin   = b;
        tick;
        query_valid = 1'b0;
        tick;
        tick;
        va = qov_a;
        ca = qcnt_a;
        cs = qcnt_s;
        cw = qcnt_w;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy_a && n < 2000) begin
            n++;
            tick;
        end
    endtask

    task automatic test_reset;
        int n;
        bit saw_q;
        logic va;
        logic [47:0] ca;
        logic [3:0] cs, cw;
        model_clear();
        rst = 1'b1;
        repeat (5) tick;
        tests++;
        if (ready_a !== 1'b0 || busy_a !== 1'b1 || qov_a !== 1'b0 || qcnt_a !== 48'd0 || ovf_a !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: ready=%b busy=%b qov=%b qcnt=%0d ovf=%b, want 0 1 0 0 0",
                     ready_a, busy_a, qov_a, qcnt_a, ovf_a);
        end
        repeat (5) tick;
        rst = 1'b0;
        tests++;
        if (ready_a !== 1'b0 || busy_a !== 1'b1 || busy_s !== 1'b1 || busy_w !== 1'b1 ||
            ready_s !== 1'b0 || ready_w !== 1'b0 || qov_a !== 1'b0 || ovf_a !== 1'b0) begin
            fails++;
            $display("FAIL reset_after_cycle: ready=%b busy=%b busy_s=%b busy_w=%b qov=%b ovf=%b, want busy and not ready",
                     ready_a, busy_a, busy_s, busy_w, qov_a, ovf_a);
        end
        // Queries issued throughout the sweep must all be dropped.
        n = 0;
        saw_q = 1'b0;
        while (busy_a && n < 2000) begin
            query_valid = 1'b1;
            query_bin   = 8'($urandom);
            n++;
            tick;
            query_valid = 1'b0;
            if (qov_a) saw_q = 1'b1;
        end
        repeat (4) begin
            tick;
            if (qov_a) saw_q = 1'b1;
        end
        tests++;
        if (n !== 257) begin
            fails++;
            $display("FAIL reset_busy_cycles: got %0d want 257", n);
        end
        tests++;
        if (saw_q !== 1'b0) begin
            fails++;
            $display("FAIL reset_query_dropped: got result valid=%b want 0", saw_q);
        end
        tests++;
        if (ready_a !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready_after: got %b want 1", ready_a);
        end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            do_query(b, va, ca, cs, cw);
            tests++;
            if (va !== 1'b1 || ca !== 48'd0) begin
                fails++;
                $display("FAIL reset_query_zero bin %0d: valid=%b count=%0d want 1 0", b, va, ca);
            end
        end
    endtask

    task automatic test_dup_keep;
        logic [95:0] d;
        bit acc0, acc1;
        logic va;
        logic [47:0] ca;
        logic [3:0] cs, cw;
        for (int i = 0; i < 8; i++) d[i*12 +: 12] = 12'h5A3;
        send_beat(d, 8'hFF, acc0);
        send_beat(d, 8'h0F, acc1);
        repeat (4) tick;
        tests++;
        if (acc0 !== 1'b1 || acc1 !== 1'b1) begin
            fails++;
            $display("FAIL dup_accept: got %b %b want 1 1", acc0, acc1);
        end
        do_query(8'h5A, va, ca, cs, cw);
        tests++;
        if (va !== 1'b1 || ca !== 48'd12) begin
            fails++;
            $display("FAIL dup_bin5A: valid=%b count=%0d want 1 12", va, ca);
        end
        do_query(8'h5B, va, ca, cs, cw);
        tests++;
        if (va !== 1'b1 || ca !== model[8'h5B]) begin
            fails++;
            $display("FAIL dup_bin5B: valid=%b count=%0d want 1 %0d", va, ca, model[8'h5B]);
        end
    endtask

    task automatic test_sat_wrap;
        int n;
        bit acc;
        logic va;
        logic [47:0] ca;
        logic [3:0] cs, cw;
        rst = 1'b1;
        repeat (3) tick;
        rst = 1'b0;
        model_clear();
        wait_idle(n);
        for (int i = 0; i < 3; i++) send_beat(96'd0, 8'hFF, acc);
        repeat (4) tick;
        do_query(8'h00, va, ca, cs, cw);
        tests++;
        if (ca !== 48'd24 || ca !== model[0]) begin
            fails++;
            $display("FAIL wide_bin0: count=%0d want 24 (model %0d)", ca, model[0]);
        end
        tests++;
        if (cs !== 4'd15 || ovf_s !== 1'b1) begin
            fails++;
            $display("FAIL saturate_bin0: count=%0d ovf=%b want 15 1", cs, ovf_s);
        end
        tests++;
        if (cw !== 4'd8 || ovf_w !== 1'b1) begin
            fails++;
            $display("FAIL wrap_bin0: count=%0d ovf=%b want 8 1", cw, ovf_w);
        end
        tests++;
        if (ovf_a !== 1'b0) begin
            fails++;
            $display("FAIL wide_no_overflow: got %b want 0", ovf_a);
        end
        do_query(8'h01, va, ca, cs, cw);
        tests++;
        if (cs !== 4'd0 || cw !== 4'd0) begin
            fails++;
            $display("FAIL narrow_bin1: sat=%0d wrap=%0d want 0 0", cs, cw);
        end
    endtask

    task automatic test_clear;
        int n;
        bit acc;
        logic va;
        logic [47:0] ca;
        logic [3:0] cs, cw;
        int bad;
        for (int i = 0; i < 50; i++) send_beat({$urandom, $urandom, $urandom}, 8'($urandom), acc);
        tests++;
        if (ovf_s !== 1'b1) begin
            fails++;
            $display("FAIL clear_pre_overflow: got %b want 1", ovf_s);
        end
        clear_req    = 1'b1;
        stream_valid = 1'b1;
        stream_data  = {$urandom, $urandom, $urandom};
        stream_keep  = 8'hFF;
        tick;
        clear_req    = 1'b0;
        stream_valid = 1'b0;
        model_clear();
        // A second clear mid-sweep must not restart it.
        n = 0;
        while (busy_a && n < 2000) begin
            clear_req = (n == 100);
            n++;
            tick;
        end
        clear_req = 1'b0;
        tests++;
        if (n !== 256) begin
            fails++;
            $display("FAIL clear_busy_cycles: got %0d want 256", n);
        end
        tests++;
        if (ovf_s !== 1'b0 || ovf_w !== 1'b0 || ovf_a !== 1'b0) begin
            fails++;
            $display("FAIL clear_overflow: sat=%b wrap=%b wide=%b want 0 0 0", ovf_s, ovf_w, ovf_a);
        end
        bad = 0;
        for (int b = 0; b < 256; b++) begin
            do_query(8'(b), va, ca, cs, cw);
            if (va !== 1'b1 || ca !== 48'd0 || cs !== 4'd0 || cw !== 4'd0) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL clear_all_bins_zero: nonzero bins=%0d want 0", bad);
        end
    endtask

    task automatic test_midsweep_reset;
        int n;
        clear_req = 1'b1;
        tick;
        clear_req = 1'b0;
        repeat (100) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        model_clear();
        wait_idle(n);
        tests++;
        if (n !== 257) begin
            fails++;
            $display("FAIL midsweep_reset_busy: got %0d want 257", n);
        end
    endtask

    task automatic test_soak;
        int acc_cnt;
        int cyc;
        acc_cnt = 0;
        cyc = 0;
        while (acc_cnt < 1000 && cyc < 5000) begin
            stream_valid = ($urandom_range(99) < 95);
            stream_keep  = 8'($urandom);
            stream_data  = {$urandom, $urandom, $urandom};
            if (stream_valid && ready_a) begin
                model_add(stream_data, stream_keep);
                acc_cnt++;
            end
            cyc++;
            tick;
        end
        stream_valid = 1'b0;
        repeat (4) tick;
        tests++;
        if (acc_cnt !== 1000) begin
            fails++;
            $display("FAIL soak_beats_accepted: got %0d want 1000", acc_cnt);
        end
        tests++;
        if (ovf_a !== 1'b0) begin
            fails++;
            $display("FAIL soak_overflow: got %b want 0", ovf_a);
        end
    endtask

    task automatic test_back_to_back;
        logic [47:0] expq [$];
        logic [47:0] e;
        int bad;
        logic [7:0] b;
        bad = 0;
        for (int i = 0; i < 514; i++) begin
            if (i < 512) begin
                b = 8'($urandom);
                query_valid = 1'b1;
                query_bin   = b;
                expq.push_back(model[b]);
            end else begin
                query_valid = 1'b0;
            end
            tick;
            if (i >= 2) begin
                e = expq.pop_front();
                tests++;
                if (qov_a !== 1'b1 || qcnt_a !== e) begin
                    fails++;
                    bad++;
                    if (bad < 10)
                        $display("FAIL b2b_query %0d: valid=%b count=%0d want 1 %0d", i - 2, qov_a, qcnt_a, e);
                end
            end else begin
                tests++;
                if (qov_a !== 1'b0 || qcnt_a !== 48'd0) begin
                    fails++;
                    $display("FAIL b2b_idle_before: valid=%b count=%0d want 0 0", qov_a, qcnt_a);
                end
            end
        end
        tick;
        tests++;
        if (qov_a !== 1'b0 || qcnt_a !== 48'd0) begin
            fails++;
            $display("FAIL b2b_idle_after: valid=%b count=%0d want 0 0", qov_a, qcnt_a);
        end
    endtask

    initial begin
        test_reset();
        test_dup_keep();
        test_sat_wrap();
        test_clear();
        test_midsweep_reset();
        test_soak();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/binned_stream_histogram.md
BINNED_STREAM_HISTOGRAM -- requirements
Module: binned_stream_histogram

Interface
REQ-001 SHALL have parameters:
- log2_words, default 3: log2 of words per beat; WORDS = 2**log2_words.
- word_width, default 12: bits per word.
- log2_bins, default 8: bins = 2**log2_bins, with 1 <= log2_bins <= word_width.
- count_width, default 48: counter width.
- SATURATE, default 1: 1 = saturate, 0 = wrap.
REQ-002 SHALL derive data_width = word_width*WORDS; word K occupies stream_data[(K+1)*word_width-1 : K*word_width].
REQ-003 SHALL have these ports:
- clk, in, 1: rising-edge clock.
- rst, in, 1: reset; one clock, reset synchronous active-high.
- stream_valid, in, 1: beat offered.
- stream_ready, out, 1: beat accepted when valid&&ready.
- stream_keep, in, WORDS: bit K=1 counts word K.
- stream_data, in, data_width: packed words.
- clear_req, in, 1: request clear of all bins.
- busy, out, 1: clear sweep in progress.
- query_valid, in, 1: query request.
- query_bin, in, log2_bins: bin queried.
- query_out_valid, out, 1: result valid.
- query_count, out, count_width: result count.
- overflow, out, 1: sticky; some counter reached max.

Function
REQ-004 SHALL map word w to bin = w[word_width-1 -: log2_bins] (upper bits).
REQ-005 SHALL, on each accepted beat, add to each bin the number of kept words mapping to it (0..WORDS); duplicates within one beat SHALL all count.
REQ-006 SHALL accept one beat per cycle whenever stream_ready=1 (no bubbles); stream_ready = !busy.
REQ-007 SHALL ignore stream_valid, stream_keep and stream_data when stream_ready=0.
REQ-008 SHALL, when SATURATE=1, clamp counts at 2**count_width-1.
REQ-009 SHALL, when SATURATE=0, wrap counts modulo 2**count_width.
REQ-010 SHALL set overflow on any increment that reaches or passes 2**count_width-1, in both modes; overflow clears only on reset or clear.
REQ-011 SHALL return query results at fixed latency 3: query accepted in cycle Q gives query_out_valid=1 and query_count in cycle Q+3, one result per query, in order, with full throughput.
REQ-012 SHALL include in query_count every beat accepted at or before cycle Q-4 and exclude every beat accepted at or after cycle Q; beats in Q-3..Q-1 are implementation-defined.
REQ-013 SHALL drop queries issued while busy=1 (no query_out_valid for them).
REQ-014 SHALL drive query_count=0 whenever query_out_valid=0.
REQ-015 SHALL have two states, SWEEP and RUN:
- SWEEP: busy=1; zeroes one bin per cycle for 2**log2_bins cycles, then RUN.
- RUN: busy=0.
REQ-016 SHALL, on clear_req=1 in RUN, enter SWEEP next cycle and discard the beat accepted in the clear_req cycle plus all in-flight increments; overflow SHALL clear.
REQ-017 SHALL ignore clear_req while busy=1; the sweep SHALL NOT restart.
REQ-018 SHALL count all bins as 0 after any sweep completes, with no residue from pipelined updates.

Reset
REQ-019 SHALL, while rst=1 and in the cycle after, drive stream_ready=0, busy=1, query_out_valid=0, query_count=0, overflow=0.
REQ-020 SHALL enter SWEEP after rst deasserts; busy falls exactly 2**log2_bins+1 cycles after rst deasserts.
REQ-021 SHALL restart the sweep from bin 0 if rst is reasserted mid-sweep or mid-stream; all in-flight beats and queries are discarded.

Verification
REQ-022 Reset sweep, defaults: rst for 10 cycles -> busy high for 257 cycles after deassert, then stream_ready=1; a query on any bin returns 0.
REQ-023 Duplicates and keep, defaults: one beat of 8 words all 0x5A3, keep=0xFF, then keep=0x0F -> bin 0x5A returns 12.
REQ-024 Saturate: count_width=4, SATURATE=1, three beats of 8x word 0x000 -> bin 0 returns 15, overflow=1.
REQ-025 Wrap: count_width=4, SATURATE=0, same stimulus -> bin 0 returns 8, overflow=1.
REQ-026 Clear: 50 random beats, clear_req with stream_valid=1 in the same cycle -> busy for 256 cycles, all 256 bins return 0, overflow=0.
REQ-027 Random soak against a reference model: 1000 beats at 95% valid with random keep, then 512 back-to-back queries -> every query_count equals the model 3 cycles after its query.
